// File: rtl/bg_pkg.sv
// Shared types and constants for the tile background generator.
package bg_pkg;

  // Pixel-to-colour latency with and without the cross-fade stage.
  localparam int unsigned BG_LAT_BASE = 2;
  localparam int unsigned BG_LAT_FADE = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COL_RED     = '{8'hFF, 8'h00, 8'h00};
  localparam rgb_t COL_BLUE    = '{8'h00, 8'h00, 8'hFF};
  localparam rgb_t COL_GREEN   = '{8'h00, 8'hFF, 8'h00};
  localparam rgb_t COL_YELLOW  = '{8'hFF, 8'hFF, 8'h00};
  localparam rgb_t COL_CYAN    = '{8'h00, 8'hFF, 8'hFF};
  localparam rgb_t COL_MAGENTA = '{8'hFF, 8'h00, 8'hFF};
  localparam rgb_t COL_WHITE   = '{8'hFF, 8'hFF, 8'hFF};
  localparam rgb_t COL_GREY    = '{8'h80, 8'h80, 8'h80};

  localparam int unsigned DEF_PAL_N = 8;

  localparam rgb_t DEFAULT_PAL [DEF_PAL_N] = '{
    COL_RED, COL_BLUE, COL_GREEN, COL_YELLOW,
    COL_CYAN, COL_MAGENTA, COL_WHITE, COL_GREY
  };

  // Default colour for palette entry i; the 8-colour set repeats for larger palettes.
  function automatic rgb_t default_colour(input int unsigned i);
    return DEFAULT_PAL[i % DEF_PAL_N];
  endfunction

endpackage

// File: rtl/bg_palette_ram.sv
// Palette register file: one write port, one read port (two with BG_CROSSFADE_EN).
// Reads are combinational from the stored array, so a read in the write cycle
// returns the old entry.
module bg_palette_ram
  import bg_pkg::*;
#(
  parameter int unsigned PAL_LOG2 = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                we_i,
  input  logic [PAL_LOG2-1:0] waddr_i,
  input  rgb_t                wdata_i,
  input  logic [PAL_LOG2-1:0] raddr0_i,
  output rgb_t                rdata0_c
`ifdef BG_CROSSFADE_EN
  ,
  input  logic [PAL_LOG2-1:0] raddr1_i,
  output rgb_t                rdata1_c
`endif
);

  localparam int unsigned ENTRIES = 2 ** PAL_LOG2;

  rgb_t pal_q [ENTRIES];

  // Storage: reload defaults on reset, otherwise one entry per write strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pal_q[i] <= default_colour(i);
      end
    end else if (we_i) begin
      pal_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_c = pal_q[raddr0_i];
`ifdef BG_CROSSFADE_EN
  assign rdata1_c = pal_q[raddr1_i];
`endif

endmodule

// File: rtl/tile_background_generator.sv
// Tiled background generator: maps screen tiles to a loadable palette and
// rotates the palette index once per frame after each timer step.
// Optional feature macro: BG_CROSSFADE_EN (blend towards the next colour, latency 3).
module tile_background_generator
  import bg_pkg::*;
#(
  parameter int unsigned CYCLES_PER_STEP = 25_000_000,
  parameter int unsigned TILE_W_LOG2     = 8,
  parameter int unsigned TILE_H_LOG2     = 8,
  parameter int unsigned TILES_X_LOG2    = 2,
  parameter int unsigned PAL_LOG2        = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [9:0]          xOrd,
  input  logic [9:0]          yOrd,
  input  logic                visible,
  input  logic                frameStart,
  input  logic                enable,
  input  logic                direction,
  input  logic                palWrite,
  input  logic [PAL_LOG2-1:0] palAddr,
  input  logic [23:0]         palData,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                pixelValid
);

`ifdef BG_CROSSFADE_EN
  localparam int unsigned LATENCY = BG_LAT_FADE;
`else
  localparam int unsigned LATENCY = BG_LAT_BASE;
`endif

  localparam int unsigned CNT_W  = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CYCLES_PER_STEP - 1);

  // Timer / rotation state
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [PAL_LOG2-1:0] rot_q, rot_d;
  logic                wrap_c;

  // Pipeline state
  logic [PAL_LOG2-1:0] idx1_q, idx1_d;
  logic [LATENCY-1:0]  vis_q, vis_d;
  rgb_t                out_q, out_d;
  logic [9:0]          tile_sum_c;
  rgb_t                rd0_c;

`ifdef BG_CROSSFADE_EN
  localparam int unsigned STEP_DIV = CYCLES_PER_STEP / 8;

  logic                dir1_q, dir1_d;
  logic [2:0]          alpha_q, alpha_d;
  rgb_t                c0_q, c0_d, c1_q, c1_d;
  rgb_t                rd1_c;
  logic [PAL_LOG2-1:0] nbr_addr_c;

  // c0 + (((c1 - c0) * alpha) >>> 3) on one 8-bit channel.
  function automatic logic [7:0] blend_ch(input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [2:0] a);
    logic signed [8:0]  diff;
    logic signed [12:0] d13;
    logic signed [12:0] a13;
    logic signed [12:0] prod;
    logic signed [12:0] sum;
    diff = $signed({1'b0, c1}) - $signed({1'b0, c0});
    d13  = 13'(diff);
    a13  = 13'($signed({1'b0, a}));
    prod = d13 * a13;
    sum  = 13'($signed({1'b0, c0})) + (prod >>> 3);
    return 8'(sum);
  endfunction

  assign nbr_addr_c = dir1_q ? (idx1_q - PAL_LOG2'(1)) : (idx1_q + PAL_LOG2'(1));
`endif

  bg_palette_ram #(
    .PAL_LOG2 (PAL_LOG2)
  ) u_pal (
    .clock    (clock),
    .reset    (reset),
    .we_i     (palWrite),
    .waddr_i  (palAddr),
    .wdata_i  (rgb_t'(palData)),
    .raddr0_i (idx1_q),
    .rdata0_c (rd0_c)
`ifdef BG_CROSSFADE_EN
    ,
    .raddr1_i (nbr_addr_c),
    .rdata1_c (rd1_c)
`endif
  );

  // Step timer and frame-synchronous rotation update.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    rot_d  = rot_q;
    wrap_c = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_TC) begin
        cnt_d  = '0;
        wrap_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pend_d = pend_q | wrap_c;
    if (frameStart && pend_d) begin
      rot_d  = direction ? (rot_q - PAL_LOG2'(1)) : (rot_q + PAL_LOG2'(1));
      pend_d = 1'b0;
    end
  end

  assign tile_sum_c = (xOrd >> TILE_W_LOG2)
                    + ((yOrd >> TILE_H_LOG2) << TILES_X_LOG2)
                    + 10'(rot_q);

  // Pixel pipeline: tile index, palette lookup, optional blend, blanking.
  always_comb begin
    idx1_d = PAL_LOG2'(tile_sum_c);
    vis_d  = {vis_q[LATENCY-2:0], visible};
`ifdef BG_CROSSFADE_EN
    dir1_d  = direction;
    c0_d    = rd0_c;
    c1_d    = rd1_c;
    alpha_d = frameStart ? 3'(cnt_q / CNT_W'(STEP_DIV)) : alpha_q;
    out_d   = '0;
    if (vis_q[1]) begin
      out_d.r = blend_ch(c0_q.r, c1_q.r, alpha_q);
      out_d.g = blend_ch(c0_q.g, c1_q.g, alpha_q);
      out_d.b = blend_ch(c0_q.b, c1_q.b, alpha_q);
    end
`else
    out_d = vis_q[0] ? rd0_c : '0;
`endif
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      rot_q   <= '0;
      idx1_q  <= '0;
      vis_q   <= '0;
      out_q   <= '0;
`ifdef BG_CROSSFADE_EN
      dir1_q  <= 1'b0;
      alpha_q <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rot_q   <= rot_d;
      idx1_q  <= idx1_d;
      vis_q   <= vis_d;
      out_q   <= out_d;
`ifdef BG_CROSSFADE_EN
      dir1_q  <= dir1_d;
      alpha_q <= alpha_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
`endif
    end
  end

  assign red        = out_q.r;
  assign green      = out_q.g;
  assign blue       = out_q.b;
  assign pixelValid = vis_q[LATENCY-1];

endmodule

// File: tb/tb_tile_background_generator.sv
// Directed bench for tile_background_generator (default build, CYCLES_PER_STEP=8).
`timescale 1ns/1ps
module tb_tile_background_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  xOrd = '0;
  logic [9:0]  yOrd = '0;
  logic        visible = 1'b0;
  logic        frameStart = 1'b0;
  logic        enable = 1'b0;
  logic        direction = 1'b0;
  logic        palWrite = 1'b0;
  logic [2:0]  palAddr = '0;
  logic [23:0] palData = '0;
  logic [7:0]  red, green, blue;
  logic        pixelValid;

  int checks = 0;
  int errors = 0;

  tile_background_generator #(
    .CYCLES_PER_STEP (8),
    .TILE_W_LOG2     (8),
    .TILE_H_LOG2     (8),
    .TILES_X_LOG2    (2),
    .PAL_LOG2        (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .xOrd       (xOrd),
    .yOrd       (yOrd),
    .visible    (visible),
    .frameStart (frameStart),
    .enable     (enable),
    .direction  (direction),
    .palWrite   (palWrite),
    .palAddr    (palAddr),
    .palData    (palData),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .pixelValid (pixelValid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    direction = 1'b0;
    frameStart = 1'b0;
    palWrite = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic pulse_frame();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    xOrd = 10'd0; yOrd = 10'd0; visible = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({red, green, blue} !== 24'h000000 || pixelValid !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: got %h valid %b, expected 000000 valid 0",
                 i, {red, green, blue}, pixelValid);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_tiles();
    logic [9:0]  vx [7];
    logic [9:0]  vy [7];
    logic [23:0] ve [7];
    vx = '{10'd0,   10'd256, 10'd512,  10'd768, 10'd256, 10'd600,  10'd0};
    vy = '{10'd0,   10'd0,   10'd0,    10'd0,   10'd256, 10'd300,  10'd512};
    ve = '{24'hFF0000, 24'h0000FF, 24'h00FF00, 24'hFFFF00, 24'hFF00FF, 24'hFFFFFF, 24'hFF0000};
    do_reset();
    visible = 1'b1;
    for (int i = 0; i < 7; i++) begin
      xOrd = vx[i]; yOrd = vy[i];
      tick(); tick();
      checks++;
      if ({red, green, blue} !== ve[i] || pixelValid !== 1'b1) begin
        errors++;
        $display("FAIL tile_%0d_%0d: got %h valid %b, expected %h valid 1",
                 vx[i], vy[i], {red, green, blue}, pixelValid, ve[i]);
      end
    end
    // Latency: (0,0) streaming, switch to (256,0); one cycle later still red.
    xOrd = 10'd0; yOrd = 10'd0;
    tick(); tick();
    xOrd = 10'd256;
    tick();
    checks++;
    if ({red, green, blue} !== 24'hFF0000) begin
      errors++;
      $display("FAIL latency_hold: got %h, expected ff0000", {red, green, blue});
    end
    tick();
    checks++;
    if ({red, green, blue} !== 24'h0000FF) begin
      errors++;
      $display("FAIL latency_two: got %h, expected 0000ff", {red, green, blue});
    end
    // Blanking.
    visible = 1'b0;
    tick();
    checks++;
    if (pixelValid !== 1'b1) begin
      errors++;
      $display("FAIL blank_delay: got valid %b, expected 1", pixelValid);
    end
    tick();
    checks++;
    if ({red, green, blue} !== 24'h000000 || pixelValid !== 1'b0) begin
      errors++;
      $display("FAIL blank: got %h valid %b, expected 000000 valid 0",
               {red, green, blue}, pixelValid);
    end
  endtask

  task automatic test_rotation();
    logic [23:0] fwd [4];
    fwd = '{24'hFF0000, 24'h0000FF, 24'h00FF00, 24'hFFFF00};
    do_reset();
    xOrd = 10'd0; yOrd = 10'd0; visible = 1'b1; enable = 1'b1;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== fwd[0]) begin
      errors++;
      $display("FAIL rot_start: got %h, expected %h", {red, green, blue}, fwd[0]);
    end
    for (int f = 1; f < 4; f++) begin
      repeat (19) tick();
      pulse_frame();
      checks++;
      if ({red, green, blue} !== fwd[f]) begin
        errors++;
        $display("FAIL rot_frame%0d: got %h, expected %h", f, {red, green, blue}, fwd[f]);
      end
    end
    do_reset();
    direction = 1'b1; enable = 1'b1;
    repeat (19) tick();
    pulse_frame();
    checks++;
    if ({red, green, blue} !== 24'h808080) begin
      errors++;
      $display("FAIL rot_back_grey: got %h, expected 808080", {red, green, blue});
    end
    repeat (19) tick();
    pulse_frame();
    checks++;
    if ({red, green, blue} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL rot_back_white: got %h, expected ffffff", {red, green, blue});
    end
    direction = 1'b0;
  endtask

  task automatic test_terminal();
    do_reset();
    xOrd = 10'd0; yOrd = 10'd0; visible = 1'b1;
    enable = 1'b1;
    repeat (6) tick();
    // frameStart at count 6 (nothing pending) and at count 7 (wrap same cycle).
    frameStart = 1'b1;
    tick();
    tick();
    frameStart = 1'b0;
    enable = 1'b0;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 24'h0000FF) begin
      errors++;
      $display("FAIL tc_same_cycle: got %h, expected 0000ff", {red, green, blue});
    end
    // Three wraps before a frame collapse to one step.
    enable = 1'b1;
    repeat (24) tick();
    enable = 1'b0;
    pulse_frame();
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL tc_collapse: got %h, expected 00ff00", {red, green, blue});
    end
    pulse_frame();
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL tc_no_pending: got %h, expected 00ff00", {red, green, blue});
    end
    // Pending step survives enable=0 until the next frame.
    enable = 1'b1;
    repeat (8) tick();
    enable = 1'b0;
    repeat (30) tick();
    checks++;
    if ({red, green, blue} !== 24'h00FF00) begin
      errors++;
      $display("FAIL tc_hold_pending: got %h, expected 00ff00", {red, green, blue});
    end
    pulse_frame();
    checks++;
    if ({red, green, blue} !== 24'hFFFF00) begin
      errors++;
      $display("FAIL tc_apply_frozen: got %h, expected ffff00", {red, green, blue});
    end
  endtask

  task automatic test_palette_write();
    do_reset();
    xOrd = 10'd0; yOrd = 10'd0; visible = 1'b1;
    tick(); tick();
    palWrite = 1'b1; palAddr = 3'd0; palData = 24'h123456;
    tick();
    palWrite = 1'b0;
    checks++;
    if ({red, green, blue} !== 24'hFF0000) begin
      errors++;
      $display("FAIL pal_old_value: got %h, expected ff0000", {red, green, blue});
    end
    tick();
    checks++;
    if ({red, green, blue} !== 24'h123456) begin
      errors++;
      $display("FAIL pal_new_value: got %h, expected 123456", {red, green, blue});
    end
    tick();
    checks++;
    if ({red, green, blue} !== 24'h123456) begin
      errors++;
      $display("FAIL pal_new_persist: got %h, expected 123456", {red, green, blue});
    end
    // Mid-frame reset flushes outputs and restores the default palette.
    reset = 1'b1;
    tick();
    checks++;
    if ({red, green, blue} !== 24'h000000 || pixelValid !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got %h valid %b, expected 000000 valid 0",
               {red, green, blue}, pixelValid);
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 24'hFF0000 || pixelValid !== 1'b1) begin
      errors++;
      $display("FAIL pal_restored: got %h valid %b, expected ff0000 valid 1",
               {red, green, blue}, pixelValid);
    end
  endtask

  initial begin
    test_reset();
    test_tiles();
    test_rotation();
    test_terminal();
    test_palette_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
